me_result_collector: RTL
========================

// Module: me_result_collector
// PURPOSE
//   Synthesizable, parametrised successor to the two-channel ME result logger.
//   Captures per-search-unit completion results (motion vector, min SAD).
//   Applies the MV offset correction in hardware.
//   Merges NCH channels into one valid/ready result stream, with round-robin
//   arbitration, FIFO buffering, per-channel block indices and overflow flags.
// PARAMETERS
//   NCH    2   number of search-unit channels (>=2)
//   MV_W   4   raw mv_x/mv_y width, two's complement
//   SAD_W  14  min SAD width, unsigned
//   DEPTH  4   output FIFO depth (power of 2, >=2)
//   X_OFS  2   offset added to raw mv_x (with wrap rule)
//   Y_OFS  1   offset added to raw mv_y (no wrap)
//   IDX_W  16  per-channel block index width
// PORTS
//   clk        in   1            clock
//   rst        in   1            asynchronous, active-low reset
//   fin        in   NCH          per-channel one-cycle completion strobe
//   mv_x       in   NCH*MV_W     raw mv_x, ch i at [i*MV_W +: MV_W]
//   mv_y       in   NCH*MV_W     raw mv_y, same packing
//   min_sad    in   NCH*SAD_W    min SAD, ch i at [i*SAD_W +: SAD_W]
//   out_valid  out  1            FIFO head valid
//   out_ready  in   1            consumer accept
//   out_ch     out  max(1,$clog2(NCH))  source channel of head record
//   out_mv_x   out  MV_W+1       corrected mv_x, signed
//   out_mv_y   out  MV_W+1       corrected mv_y, signed
//   out_sad    out  SAD_W        min SAD
//   out_idx    out  IDX_W        per-channel block index of record
//   ovf        out  NCH          sticky overflow flag per channel
//   ovf_clr    in   1            synchronous clear of all ovf bits
// BEHAVIOUR
// - Reset: all outputs 0.
//   - Pending regs empty, FIFO empty, block indices 0.
//   - RR pointer = NCH-1, so ch0 has first priority.
// - Capture: fin[i]=1 at an edge stores ch i fields in pending[i].
//   - Correction is applied at capture.
//   - x = sext(mv_x)+X_OFS. If x > 2^(MV_W-1), x -= 2^MV_W.
//     Example: 7 -> -7, 6 -> 8, -8 -> -6.
//   - y = sext(mv_y)+Y_OFS, computed in MV_W+1 bits.
//   - idx[i] is attached, then incremented (wraps at 2^IDX_W).
// - Grant: at most one channel per cycle.
//   - Candidates are pending channels; search starts at rr_ptr+1, modulo NCH.
//   - Write is allowed when FIFO count < DEPTH, or when a pop occurs the
//     same cycle.
//   - On write: pending[g] is cleared and rr_ptr becomes g.
//   - FIFO full with no pop: no grant, pending is held.
// - Overflow: fin[i] while pending[i] is set and ch i is not granted that cycle:
//   - New result is dropped, ovf[i] is set, idx[i] is not incremented.
//   - fin[i] in the same cycle ch i is granted: old result goes to FIFO, new
//     result is captured, no overflow.
// - ovf_clr and a new overflow in the same cycle: the set wins.
// - Output: out_valid = FIFO not empty.
//   - out_* show the head record and stay stable while out_valid && !out_ready.
//   - Pop on out_valid && out_ready.
// - Latency: fin at edge t, grant at edge t+1, out_valid high in cycle t+2.
//   - Minimum latency is 2 cycles.
//   - Throughput is 1 record/cycle sustained.
// - Record order: FIFO order equals grant order. Per-channel order is always
//   preserved.
// - Reset asserted mid-operation: asynchronously clears FIFO, pending regs,
//   indices, ovf and rr_ptr.
//   - out_valid falls with no clock edge.
//   - Records in flight are discarded.
// TESTING
// 1. Single record: ch0 fin, mv_x=3, mv_y=-2, sad=100, out_ready=1
//    -> cycle t+2: out_valid=1, ch=0, x=5, y=-1, sad=100, idx=0.
// 2. Wrap: ch1 mv_x=7 / 6 / -8, one fin each, mv_y=7
//    -> x=-7, 8, -6; y=8; idx=0, 1, 2.
// 3. Simultaneous fin on ch0 and ch1, repeated twice
//    -> output order ch0, ch1, ch0, ch1 on consecutive cycles.
// 4. Backpressure, out_ready=0, 6 fins alternating ch0/ch1
//    -> FIFO holds 4, 2 pending, ovf=0.
//    Then ch0 fin -> ovf[0]=1, value dropped.
//    Then ready=1 -> 6 records in grant order, idx contiguous.
// 5. Full FIFO with out_ready=1 and pending ch1
//    -> pop and write in the same cycle, count stays DEPTH, no stall.
// 6. Reset mid-stream with 3 records buffered: rst low
//    -> out_valid=0 and ovf=0 immediately.
//    After release, first fin -> idx=0.
//    Also: ovf_clr together with a new overflow -> ovf stays 1.

Source files
------------

// File: rtl/me_result_collector.sv
// Collects motion-estimation results from NCH search units, applies the MV offset
// correction, and merges them round-robin into one buffered valid/ready stream.
module me_result_collector #(
    parameter int NCH   = 2,
    parameter int MV_W  = 4,
    parameter int SAD_W = 14,
    parameter int DEPTH = 4,
    parameter int X_OFS = 2,
    parameter int Y_OFS = 1,
    parameter int IDX_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NCH-1:0]                        fin,
    input  logic [NCH*MV_W-1:0]                   mv_x,
    input  logic [NCH*MV_W-1:0]                   mv_y,
    input  logic [NCH*SAD_W-1:0]                  min_sad,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
    output logic signed [MV_W:0]                  out_mv_x,
    output logic signed [MV_W:0]                  out_mv_y,
    output logic [SAD_W-1:0]                      out_sad,
    output logic [IDX_W-1:0]                      out_idx,
    output logic [NCH-1:0]                        ovf,
    input  logic                                  ovf_clr
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam logic signed [MV_W:0] X_LIM  = (MV_W+1)'(2**(MV_W-1));
    localparam logic        [MV_W:0] X_SPAN = (MV_W+1)'(2**MV_W);

    function automatic logic signed [MV_W:0] fix_x(input logic signed [MV_W-1:0] mv);
        logic signed [MV_W:0] v;
        v = {mv[MV_W-1], mv} + (MV_W+1)'(X_OFS);
        if (v > X_LIM)
            v = v - X_SPAN;
        return v;
    endfunction

    function automatic logic signed [MV_W:0] fix_y(input logic signed [MV_W-1:0] mv);
        logic signed [MV_W:0] v;
        v = {mv[MV_W-1], mv} + (MV_W+1)'(Y_OFS);
        return v;
    endfunction

    logic [NCH-1:0]        vld_p0;
    logic signed [MV_W:0]  mvx_p0 [NCH];
    logic signed [MV_W:0]  mvy_p0 [NCH];
    logic [SAD_W-1:0]      sad_p0 [NCH];
    logic [IDX_W-1:0]      idx_p0 [NCH];
    logic [IDX_W-1:0]      idx_cnt [NCH];
    logic [CHW-1:0]        rr_ptr;

    logic [CHW-1:0]        ch_p1  [DEPTH];
    logic signed [MV_W:0]  mvx_p1 [DEPTH];
    logic signed [MV_W:0]  mvy_p1 [DEPTH];
    logic [SAD_W-1:0]      sad_p1 [DEPTH];
    logic [IDX_W-1:0]      idx_p1 [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;

    logic                  pop;
    logic                  gnt_hit;
    logic                  gnt_vld;
    logic [CHW-1:0]        gnt_ch;
    logic [CHW-1:0]        scan_ch;
    logic [NCH-1:0]        gnt_oh;
    logic [NCH-1:0]        cap;
    logic [NCH-1:0]        ovf_set;

    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready;

    // Round-robin scan starting just after the last granted channel
    always_comb begin
        gnt_hit = 1'b0;
        gnt_ch  = '0;
        scan_ch = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan_ch = CHW'((int'(rr_ptr) + k) % NCH);
            if (!gnt_hit && vld_p0[scan_ch]) begin
                gnt_hit = 1'b1;
                gnt_ch  = scan_ch;
            end
        end
        gnt_vld = gnt_hit && ((cnt < CW'(DEPTH)) || pop);
    end

    // A channel granted this cycle frees its slot, so a coincident fin is captured
    always_comb begin
        gnt_oh  = '0;
        cap     = '0;
        ovf_set = '0;
        for (int i = 0; i < NCH; i++) begin
            gnt_oh[i]  = gnt_vld && (gnt_ch == CHW'(i));
            cap[i]     = fin[i] && (!vld_p0[i] || gnt_oh[i]);
            ovf_set[i] = fin[i] && vld_p0[i] && !gnt_oh[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= '0;
            for (int i = 0; i < NCH; i++)
                idx_cnt[i] <= '0;
            rr_ptr <= CHW'(NCH - 1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cap[i]) begin
                    vld_p0[i]  <= 1'b1;
                    idx_cnt[i] <= idx_cnt[i] + IDX_W'(1);
                end else if (gnt_oh[i]) begin
                    vld_p0[i]  <= 1'b0;
                end
            end
            if (gnt_vld) begin
                rr_ptr <= gnt_ch;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(gnt_vld) - CW'(pop);
            ovf <= (ovf & ~{NCH{ovf_clr}}) | ovf_set;
        end
    end

    // Stage p0: corrected capture per channel; stage p1: shared output FIFO
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (cap[i]) begin
                mvx_p0[i] <= fix_x(mv_x[i*MV_W +: MV_W]);
                mvy_p0[i] <= fix_y(mv_y[i*MV_W +: MV_W]);
                sad_p0[i] <= min_sad[i*SAD_W +: SAD_W];
                idx_p0[i] <= idx_cnt[i];
            end
        end
        if (gnt_vld) begin
            ch_p1[wr_ptr]  <= gnt_ch;
            mvx_p1[wr_ptr] <= mvx_p0[gnt_ch];
            mvy_p1[wr_ptr] <= mvy_p0[gnt_ch];
            sad_p1[wr_ptr] <= sad_p0[gnt_ch];
            idx_p1[wr_ptr] <= idx_p0[gnt_ch];
        end
    end

    // Data storage is not reset; outputs read as zero whenever the FIFO is empty
    assign out_ch   = out_valid ? ch_p1[rd_ptr]  : '0;
    assign out_mv_x = out_valid ? mvx_p1[rd_ptr] : '0;
    assign out_mv_y = out_valid ? mvy_p1[rd_ptr] : '0;
    assign out_sad  = out_valid ? sad_p1[rd_ptr] : '0;
    assign out_idx  = out_valid ? idx_p1[rd_ptr] : '0;

endmodule
